// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// EX-stage companion of the gshare BTB predictor. Each fetched PC travels with
// its prediction through IF/ID and ID/EX tracking registers. When it reaches EX,
// the resolved outcome is checked against what was predicted. From that check
// the unit drives:
//   - the predictor update port (bp_*),
//   - the fetch redirect/flush (redirect, redirect_pc),
//   - two saturating performance counters.
//
// Update-port protocol: bp_valid is a single-cycle strobe with no ready
// back-pressure. The predictor must consume bp_taken, bp_ex_addr and
// bp_target_addr in the same cycle that bp_valid is high. Those payload
// signals are held at zero whenever bp_valid is low.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_hit,
  input  logic             if_prediction,
  input  logic [XLEN-1:0]  if_pred_target,
  input  logic             stall,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             bp_valid,
  output logic             bp_taken,
  output logic [XLEN-1:0]  bp_ex_addr,
  output logic [XLEN-1:0]  bp_target_addr,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  // A taken prediction is only meaningful when the BTB actually hit.
  logic if_ptaken;
  assign if_ptaken = if_hit & if_prediction;

  // IF/ID tracking register
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic            id_ptaken;
  logic [XLEN-1:0] id_ptarget;

  // ID/EX tracking register
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_ptaken;
  logic [XLEN-1:0] ex_ptarget;

  // Resolution terms
  logic ex_is_branch;
  logic dir_miss;
  logic tgt_miss;
  logic branch_miss;
  logic alias_miss;
  logic mispredict;

  // Tracking registers.
  // Priority: reset, then flush on redirect, then stall (hold ID and
  // bubble into EX), then normal advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_ptaken  <= 1'b0;
      id_ptarget <= '0;
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_ptaken  <= 1'b0;
      ex_ptarget <= '0;
    end else if (mispredict) begin
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (stall) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_ptaken  <= id_ptaken;
      ex_ptarget <= id_ptarget;
      id_valid   <= if_valid;
      id_pc      <= if_pc;
      id_ptaken  <= if_ptaken;
      id_ptarget <= if_pred_target;
    end
  end

  // Misprediction detection for the instruction currently in EX.
  // Two cases are treated as a mispredict:
  //   - a real branch whose direction differs from the prediction, or which
  //     is taken as predicted but to a different target;
  //   - a non-branch that the BTB claimed as taken (an alias hit). Its
  //     sequential successor was never fetched, so fetch must be redirected.
  always_comb begin
    ex_is_branch = ex_valid & ex_branch;
    dir_miss     = ex_taken ^ ex_ptaken;
    tgt_miss     = ex_taken & ex_ptaken & (ex_ptarget != ex_target);
    branch_miss  = ex_is_branch & (dir_miss | tgt_miss);
    alias_miss   = ex_valid & ~ex_branch & ex_ptaken;
    mispredict   = branch_miss | alias_miss;
  end

  // Redirect is issued in the same cycle as the mispredict.
  // The correct next PC is the resolved target when a branch is taken,
  // otherwise the fall-through PC (ex_pc + 4, wrapping at XLEN bits).
  always_comb begin
    redirect    = mispredict;
    redirect_pc = '0;
    if (mispredict) begin
      if (ex_branch && ex_taken) begin
        redirect_pc = ex_target;
      end else begin
        redirect_pc = ex_pc + XLEN'(4);
      end
    end
  end

  // Predictor update: issued for every resolved branch, hit or miss, since
  // the PHT/BHSR also train on not-taken outcomes. Alias mispredicts never
  // update the predictor.
  always_comb begin
    bp_valid       = ex_is_branch;
    bp_taken       = 1'b0;
    bp_ex_addr     = '0;
    bp_target_addr = '0;
    if (ex_is_branch) begin
      bp_taken       = ex_taken;
      bp_ex_addr     = ex_pc;
      bp_target_addr = ex_target;
    end
  end

  // Performance counters.
  // Each counter sticks at all-ones rather than wrapping, so a long run
  // never reports a misleadingly small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (bp_valid && (branch_count != {CNT_W{1'b1}})) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (redirect && (mispredict_count != {CNT_W{1'b1}})) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, which is well away from the rising edge.
// A second instance with 3-bit counters exercises counter saturation.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_hit;
  logic        if_prediction;
  logic [31:0] if_pred_target;
  logic        stall;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_target;

  // Outputs of the main instance (32-bit counters)
  logic        bp_valid;
  logic        bp_taken;
  logic [31:0] bp_ex_addr;
  logic [31:0] bp_target_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // Outputs of the small-counter instance
  logic        s_bp_valid;
  logic        s_bp_taken;
  logic [31:0] s_bp_ex_addr;
  logic [31:0] s_bp_target_addr;
  logic        s_redirect;
  logic [31:0] s_redirect_pc;
  logic [2:0]  s_bc;
  logic [2:0]  s_mc;

  int checks;
  int failures;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT instances
  // ---------------------------------------------------------------------------
  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
    .if_prediction(if_prediction), .if_pred_target(if_pred_target),
    .stall(stall), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_ex_addr(bp_ex_addr),
    .bp_target_addr(bp_target_addr), .redirect(redirect),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
    .if_prediction(if_prediction), .if_pred_target(if_pred_target),
    .stall(stall), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .bp_valid(s_bp_valid), .bp_taken(s_bp_taken), .bp_ex_addr(s_bp_ex_addr),
    .bp_target_addr(s_bp_target_addr), .redirect(s_redirect),
    .redirect_pc(s_redirect_pc), .branch_count(s_bc),
    .mispredict_count(s_mc)
  );

  // All observed outputs packed into one vector, so a single comparison
  // covers everything.
  logic [168:0] obs_vec;
  assign obs_vec = {bp_valid, bp_taken, bp_ex_addr, bp_target_addr, redirect,
                    redirect_pc, branch_count, mispredict_count, s_bc, s_mc};

  logic s_same;
  assign s_same = ({s_bp_valid, s_bp_taken, s_bp_ex_addr, s_bp_target_addr,
                    s_redirect, s_redirect_pc} ===
                   {bp_valid, bp_taken, bp_ex_addr, bp_target_addr,
                    redirect, redirect_pc});

  // ---------------------------------------------------------------------------
  // Reference model: the instruction in each stage plus counter totals.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptgt;
  } slot_t;

  slot_t  m_id;
  slot_t  m_ex;
  longint m_bc;
  longint m_mc;
  int     m_sbc;
  int     m_smc;

  // Expected values for the current cycle
  logic         e_br;
  logic         e_mis;
  logic [31:0]  e_rpc;
  logic [168:0] e_vec;

  // Compute expected outputs from the model state and the current inputs.
  function automatic void calc();
    e_br = m_ex.v && ex_branch;

    if (!m_ex.v) begin
      e_mis = 1'b0;
    end else if (ex_branch) begin
      e_mis = (ex_taken != m_ex.pt) ||
              (ex_taken && m_ex.pt && (m_ex.ptgt != ex_target));
    end else begin
      e_mis = m_ex.pt;
    end

    if (!e_mis) begin
      e_rpc = 32'h0;
    end else if (ex_branch && ex_taken) begin
      e_rpc = ex_target;
    end else begin
      e_rpc = m_ex.pc + 32'd4;
    end

    e_vec = {e_br, e_br & ex_taken, e_br ? m_ex.pc : 32'h0,
             e_br ? ex_target : 32'h0, e_mis, e_rpc,
             m_bc[31:0], m_mc[31:0], m_sbc[2:0], m_smc[2:0]};
  endfunction

  // Advance one clock: apply the edge to the model with the inputs held
  // steady, then return to the falling edge.
  task automatic tick();
    calc();
    @(posedge clk);
    if (reset) begin
      m_id = '{0, 32'h0, 0, 32'h0};
      m_ex = '{0, 32'h0, 0, 32'h0};
      m_bc = 0;
      m_mc = 0;
      m_sbc = 0;
      m_smc = 0;
    end else begin
      if (e_br) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc = m_bc + 1;
        if (m_sbc < 7) m_sbc = m_sbc + 1;
      end
      if (e_mis) begin
        if (m_mc < 64'hFFFF_FFFF) m_mc = m_mc + 1;
        if (m_smc < 7) m_smc = m_smc + 1;
        m_id.v = 0;
        m_ex.v = 0;
      end else if (stall) begin
        m_ex.v = 0;
      end else begin
        m_ex = m_id;
        m_id = '{if_valid, if_pc, if_hit & if_prediction, if_pred_target};
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_valid       = 1'b0;
    if_pc          = 32'h0;
    if_hit         = 1'b0;
    if_prediction  = 1'b0;
    if_pred_target = 32'h0;
    stall          = 1'b0;
    ex_branch      = 1'b0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------

  // After reset and while idle, every output and counter is zero.
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      calc();
      checks++;
      if (obs_vec !== 169'h0 || e_vec !== 169'h0) begin
        $display("FAIL reset_idle cyc=%0d obs=%h exp=0", i, obs_vec);
        failures++;
      end
      tick();
    end
  endtask

  // Branch predicted not-taken resolves not-taken: update only, no redirect.
  task automatic test_correct_not_taken();
    do_reset();
    if_valid = 1'b1;
    if_pc    = 32'h100;
    tick();
    clear_inputs();
    tick();

    ex_branch = 1'b1;
    ex_taken  = 1'b0;
    #1;
    calc();
    checks++;
    if ({bp_valid, bp_taken, bp_ex_addr, redirect} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
      $display("FAIL correct_nt bp_valid=%b bp_taken=%b addr=%h redirect=%b exp 1 0 00000100 0",
               bp_valid, bp_taken, bp_ex_addr, redirect);
      failures++;
    end
    checks++;
    if (obs_vec !== e_vec) begin
      $display("FAIL correct_nt_model obs=%h exp=%h", obs_vec, e_vec);
      failures++;
    end
    tick();

    clear_inputs();
    #1;
    checks++;
    if (branch_count !== 32'd1 || mispredict_count !== 32'd0) begin
      $display("FAIL correct_nt_count bc=%0d mc=%0d exp 1 0", branch_count, mispredict_count);
      failures++;
    end
  endtask

  // Predicted not-taken but resolved taken: redirect to the target, and the
  // two younger instructions are flushed.
  task automatic test_direction_miss();
    do_reset();
    if_valid = 1'b1;
    if_pc    = 32'h200;
    tick();
    if_pc = 32'h204;
    tick();

    if_pc     = 32'h208;
    ex_branch = 1'b1;
    ex_taken  = 1'b1;
    ex_target = 32'h80;
    #1;
    calc();
    checks++;
    if ({redirect, redirect_pc, bp_valid, bp_taken} !== {1'b1, 32'h80, 1'b1, 1'b1}) begin
      $display("FAIL dir_miss redirect=%b pc=%h bp_valid=%b bp_taken=%b exp 1 00000080 1 1",
               redirect, redirect_pc, bp_valid, bp_taken);
      failures++;
    end
    tick();

    // Both tracking stages were flushed, so EX must ignore ex_branch here.
    if_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      calc();
      checks++;
      if (bp_valid !== 1'b0 || redirect !== 1'b0 || obs_vec !== e_vec) begin
        $display("FAIL dir_miss_flush cyc=%0d bp_valid=%b redirect=%b obs=%h exp=%h",
                 i, bp_valid, redirect, obs_vec, e_vec);
        failures++;
      end
      tick();
    end

    #1;
    checks++;
    if (mispredict_count !== 32'd1 || branch_count !== 32'd1) begin
      $display("FAIL dir_miss_count mc=%0d bc=%0d exp 1 1", mispredict_count, branch_count);
      failures++;
    end
  endtask

  // Predicted taken to 0x400 but resolved taken to 0x440: target miss.
  task automatic test_target_miss();
    do_reset();
    if_valid       = 1'b1;
    if_pc          = 32'h300;
    if_hit         = 1'b1;
    if_prediction  = 1'b1;
    if_pred_target = 32'h400;
    tick();
    clear_inputs();
    tick();

    ex_branch = 1'b1;
    ex_taken  = 1'b1;
    ex_target = 32'h440;
    #1;
    calc();
    checks++;
    if ({redirect, redirect_pc, bp_valid, bp_target_addr} !== {1'b1, 32'h440, 1'b1, 32'h440}) begin
      $display("FAIL target_miss redirect=%b pc=%h bp_valid=%b tgt=%h exp 1 00000440 1 00000440",
               redirect, redirect_pc, bp_valid, bp_target_addr);
      failures++;
    end
    tick();
  endtask

  // A non-branch predicted taken (alias hit), delayed by one stall cycle.
  task automatic test_alias_stall();
    do_reset();
    if_valid       = 1'b1;
    if_pc          = 32'h500;
    if_hit         = 1'b1;
    if_prediction  = 1'b1;
    if_pred_target = 32'h600;
    tick();

    // Stall: the IF/ID slot is held and a bubble goes into ID/EX.
    // The instruction presented in IF meanwhile must be ignored.
    stall     = 1'b1;
    if_pc     = 32'h504;
    if_hit    = 1'b0;
    ex_branch = 1'b1;
    ex_taken  = 1'b1;
    #1;
    calc();
    checks++;
    if (bp_valid !== 1'b0 || redirect !== 1'b0) begin
      $display("FAIL alias_stall_cyc bp_valid=%b redirect=%b exp 0 0", bp_valid, redirect);
      failures++;
    end
    tick();

    stall    = 1'b0;
    if_valid = 1'b0;
    #1;
    calc();
    checks++;
    if (bp_valid !== 1'b0 || redirect !== 1'b0 || obs_vec !== e_vec) begin
      $display("FAIL alias_bubble bp_valid=%b redirect=%b exp 0 0", bp_valid, redirect);
      failures++;
    end
    tick();

    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    #1;
    calc();
    checks++;
    if ({redirect, redirect_pc, bp_valid} !== {1'b1, 32'h504, 1'b0}) begin
      $display("FAIL alias_redirect redirect=%b pc=%h bp_valid=%b exp 1 00000504 0",
               redirect, redirect_pc, bp_valid);
      failures++;
    end
    tick();

    #1;
    checks++;
    if (mispredict_count !== 32'd1 || branch_count !== 32'd0) begin
      $display("FAIL alias_count mc=%0d bc=%0d exp 1 0", mispredict_count, branch_count);
      failures++;
    end
  endtask

  // A not-taken miss at the top of the address space wraps the fall-through
  // PC to zero.
  task automatic test_wrap();
    do_reset();
    if_valid       = 1'b1;
    if_pc          = 32'hFFFF_FFFC;
    if_hit         = 1'b1;
    if_prediction  = 1'b1;
    if_pred_target = 32'h10;
    tick();
    clear_inputs();
    tick();

    ex_branch = 1'b1;
    ex_taken  = 1'b0;
    #1;
    calc();
    checks++;
    if ({redirect, redirect_pc, bp_valid, bp_ex_addr} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL wrap redirect=%b pc=%h bp_valid=%b addr=%h exp 1 00000000 1 fffffffc",
               redirect, redirect_pc, bp_valid, bp_ex_addr);
      failures++;
    end
    tick();
  endtask

  // Back-to-back branches and redirects drive the 3-bit counters to
  // all-ones, where they must stay.
  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if_valid  = 1'b1;
      if_pc     = 32'h1000 + 32'(4 * i);
      ex_branch = 1'b1;
      ex_taken  = 1'b0;
      #1;
      calc();
      checks++;
      if (obs_vec !== e_vec || !s_same) begin
        $display("FAIL sat_branch cyc=%0d obs=%h exp=%h", i, obs_vec, e_vec);
        failures++;
      end
      tick();
    end

    ex_branch = 1'b0;
    #1;
    checks++;
    if (s_bc !== 3'd7 || branch_count !== 32'd10) begin
      $display("FAIL sat_bc small=%0d big=%0d exp 7 10", s_bc, branch_count);
      failures++;
    end

    for (int i = 0; i < 30; i++) begin
      if_valid  = 1'b1;
      if_pc     = 32'h2000 + 32'(4 * i);
      ex_branch = 1'b1;
      ex_taken  = 1'b1;
      ex_target = 32'h3000;
      #1;
      calc();
      checks++;
      if (obs_vec !== e_vec || !s_same) begin
        $display("FAIL sat_mis cyc=%0d obs=%h exp=%h", i, obs_vec, e_vec);
        failures++;
      end
      tick();
    end

    clear_inputs();
    #1;
    checks++;
    if (s_mc !== 3'd7 || s_bc !== 3'd7) begin
      $display("FAIL sat_mc small_mc=%0d small_bc=%0d exp 7 7", s_mc, s_bc);
      failures++;
    end
  endtask

  // A reset arriving while a mispredicting branch sits in EX clears
  // everything by the following cycle.
  task automatic test_reset_mid();
    do_reset();
    if_valid = 1'b1;
    if_pc    = 32'h700;
    tick();
    tick();

    ex_branch = 1'b1;
    ex_taken  = 1'b1;
    ex_target = 32'h900;
    reset     = 1'b1;
    tick();

    reset = 1'b0;
    #1;
    calc();
    checks++;
    if (obs_vec !== 169'h0 || e_vec !== 169'h0) begin
      $display("FAIL reset_mid obs=%h exp=0", obs_vec);
      failures++;
    end
    tick();
    clear_inputs();
  endtask

  // Randomised traffic checked cycle by cycle against the model.
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 60) == 0);
      if_valid       = $urandom_range(0, 3) != 0;
      if_pc          = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if_hit         = $urandom_range(0, 1);
      if_prediction  = $urandom_range(0, 1);
      if_pred_target = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      stall          = ($urandom_range(0, 4) == 0);
      ex_branch      = $urandom_range(0, 3) != 0;
      ex_taken       = $urandom_range(0, 1);
      ex_target      = ($urandom_range(0, 1) == 1) ? m_ex.ptgt
                                                   : {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      #1;
      calc();
      checks++;
      if (obs_vec !== e_vec || !s_same) begin
        $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec, e_vec);
        failures++;
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    m_id  = '{0, 32'h0, 0, 32'h0};
    m_ex  = '{0, 32'h0, 0, 32'h0};
    m_bc  = 0;
    m_mc  = 0;
    m_sbc = 0;
    m_smc = 0;
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);

    test_reset();
    test_correct_not_taken();
    test_direction_miss();
    test_target_miss();
    test_alias_stall();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
